// File: rtl/montgomery_constant_feeder.sv
// Block-serial store for the Montgomery constants k and N, served one block at a time to the reduction stage.
// Optional debug pass counters are enabled by defining CONST_FEEDER_PASS_CNT_EN.
module montgomery_constant_feeder #(
    parameter int unsigned REGISTER_SIZE = 32,
    parameter int unsigned NUM_BLOCKS    = 128,
    parameter int unsigned PTR_W         = $clog2(NUM_BLOCKS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     load_valid_in,
    input  logic                     load_sel_in,
    input  logic [REGISTER_SIZE-1:0] load_block_in,
    output logic                     load_done_out,
    input  logic                     start_in,
    input  logic                     consumed_k_in,
    input  logic                     consumed_N_in,
    output logic [REGISTER_SIZE-1:0] k_block_out,
    output logic [REGISTER_SIZE-1:0] N_block_out,
    output logic                     k_wrap_out,
    output logic                     N_wrap_out,
    output logic                     ready_out,
    output logic [7:0]               k_pass_cnt_out,
    output logic [7:0]               N_pass_cnt_out
);

    localparam logic [PTR_W-1:0] LAST_BLK = PTR_W'(NUM_BLOCKS - 1);

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_BLK) ? '0 : p + PTR_W'(1);
    endfunction

    logic [REGISTER_SIZE-1:0] kmem_q [NUM_BLOCKS];
    logic [REGISTER_SIZE-1:0] nmem_q [NUM_BLOCKS];

    logic [PTR_W-1:0] k_ptr_q,  k_ptr_d;
    logic [PTR_W-1:0] n_ptr_q,  n_ptr_d;
    logic [PTR_W-1:0] lptr_k_q, lptr_k_d;
    logic [PTR_W-1:0] lptr_n_q, lptr_n_d;
    logic             loaded_k_q, loaded_k_d;
    logic             loaded_n_q, loaded_n_d;
    logic             load_done_q, load_done_d;
    logic             k_wrap_q, k_wrap_d;
    logic             n_wrap_q, n_wrap_d;
    logic             ready_q, ready_d;

    // Storage: synchronous write, no reset on contents
    always_ff @(posedge clk_in) begin
        if (load_valid_in && !load_sel_in) kmem_q[lptr_k_q] <= load_block_in;
        if (load_valid_in &&  load_sel_in) nmem_q[lptr_n_q] <= load_block_in;
    end

    // Asynchronous read: the current block follows the pointer with no latency
    assign k_block_out = kmem_q[k_ptr_q];
    assign N_block_out = nmem_q[n_ptr_q];

    always_comb begin
        k_ptr_d     = k_ptr_q;
        n_ptr_d     = n_ptr_q;
        k_wrap_d    = 1'b0;
        n_wrap_d    = 1'b0;
        lptr_k_d    = lptr_k_q;
        lptr_n_d    = lptr_n_q;
        loaded_k_d  = loaded_k_q;
        loaded_n_d  = loaded_n_q;
        load_done_d = 1'b0;
        ready_d     = loaded_k_q & loaded_n_q;

        // start_in rewinds both pointers and suppresses any wrap from a coincident consume
        if (start_in) begin
            k_ptr_d = '0;
            n_ptr_d = '0;
        end else begin
            if (consumed_k_in) begin
                k_ptr_d  = ptr_inc(k_ptr_q);
                k_wrap_d = (k_ptr_q == LAST_BLK);
            end
            if (consumed_N_in) begin
                n_ptr_d  = ptr_inc(n_ptr_q);
                n_wrap_d = (n_ptr_q == LAST_BLK);
            end
        end

        if (load_valid_in) begin
            if (!load_sel_in) begin
                lptr_k_d = ptr_inc(lptr_k_q);
                if (lptr_k_q == LAST_BLK) begin
                    loaded_k_d  = 1'b1;
                    load_done_d = 1'b1;
                end
            end else begin
                lptr_n_d = ptr_inc(lptr_n_q);
                if (lptr_n_q == LAST_BLK) begin
                    loaded_n_d  = 1'b1;
                    load_done_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            k_ptr_q     <= '0;
            n_ptr_q     <= '0;
            lptr_k_q    <= '0;
            lptr_n_q    <= '0;
            loaded_k_q  <= 1'b0;
            loaded_n_q  <= 1'b0;
            load_done_q <= 1'b0;
            k_wrap_q    <= 1'b0;
            n_wrap_q    <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            k_ptr_q     <= k_ptr_d;
            n_ptr_q     <= n_ptr_d;
            lptr_k_q    <= lptr_k_d;
            lptr_n_q    <= lptr_n_d;
            loaded_k_q  <= loaded_k_d;
            loaded_n_q  <= loaded_n_d;
            load_done_q <= load_done_d;
            k_wrap_q    <= k_wrap_d;
            n_wrap_q    <= n_wrap_d;
            ready_q     <= ready_d;
        end
    end

    assign load_done_out = load_done_q;
    assign k_wrap_out    = k_wrap_q;
    assign N_wrap_out    = n_wrap_q;
    assign ready_out     = ready_q;

`ifdef CONST_FEEDER_PASS_CNT_EN
    logic [7:0] k_pass_q, k_pass_d;
    logic [7:0] n_pass_q, n_pass_d;

    // Pass counters count wraps and restart with every reduction
    always_comb begin
        k_pass_d = k_pass_q;
        n_pass_d = n_pass_q;
        if (start_in) begin
            k_pass_d = '0;
            n_pass_d = '0;
        end else begin
            if (k_wrap_d) k_pass_d = k_pass_q + 8'(1);
            if (n_wrap_d) n_pass_d = n_pass_q + 8'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            k_pass_q <= '0;
            n_pass_q <= '0;
        end else begin
            k_pass_q <= k_pass_d;
            n_pass_q <= n_pass_d;
        end
    end

    assign k_pass_cnt_out = k_pass_q;
    assign N_pass_cnt_out = n_pass_q;
`else
    assign k_pass_cnt_out = 8'd0;
    assign N_pass_cnt_out = 8'd0;
`endif

endmodule

// File: tb/tb_montgomery_constant_feeder.sv
// Directed self-checking bench for montgomery_constant_feeder.
module tb_montgomery_constant_feeder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        load_valid_in;
    logic        load_sel_in;
    logic [31:0] load_block_in;
    logic        load_done_out;
    logic        start_in;
    logic        consumed_k_in;
    logic        consumed_N_in;
    logic [31:0] k_block_out;
    logic [31:0] N_block_out;
    logic        k_wrap_out;
    logic        N_wrap_out;
    logic        ready_out;
    logic [7:0]  k_pass_cnt_out;
    logic [7:0]  N_pass_cnt_out;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

`ifdef CONST_FEEDER_PASS_CNT_EN
    localparam int PASS_ONE = 1;
`else
    localparam int PASS_ONE = 0;
`endif

    montgomery_constant_feeder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .load_valid_in  (load_valid_in),
        .load_sel_in    (load_sel_in),
        .load_block_in  (load_block_in),
        .load_done_out  (load_done_out),
        .start_in       (start_in),
        .consumed_k_in  (consumed_k_in),
        .consumed_N_in  (consumed_N_in),
        .k_block_out    (k_block_out),
        .N_block_out    (N_block_out),
        .k_wrap_out     (k_wrap_out),
        .N_wrap_out     (N_wrap_out),
        .ready_out      (ready_out),
        .k_pass_cnt_out (k_pass_cnt_out),
        .N_pass_cnt_out (N_pass_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Advance one edge, then settle so outputs are sampled away from it
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        rst_in = 1'b1; load_valid_in = 1'b0; load_sel_in = 1'b0; load_block_in = '0;
        start_in = 1'b0; consumed_k_in = 1'b0; consumed_N_in = 1'b0;
        tick();
        check("rst_ready",     32'(ready_out),      32'd0);
        check("rst_load_done", 32'(load_done_out),  32'd0);
        check("rst_k_wrap",    32'(k_wrap_out),     32'd0);
        check("rst_N_wrap",    32'(N_wrap_out),     32'd0);
        check("rst_k_pass",    32'(k_pass_cnt_out), 32'd0);
        check("rst_N_pass",    32'(N_pass_cnt_out), 32'd0);
        rst_in = 1'b0;
        tick();

        // Load k then N
        pulses = 0;
        for (int i = 0; i < 128; i++) begin
            load_valid_in = 1'b1; load_sel_in = 1'b0; load_block_in = 32'h1000 + 32'(i);
            tick();
            if (load_done_out) pulses++;
        end
        check("k_last_done", 32'(load_done_out), 32'd1);
        check("ready_k_only", 32'(ready_out), 32'd0);
        for (int i = 0; i < 128; i++) begin
            load_valid_in = 1'b1; load_sel_in = 1'b1; load_block_in = 32'h2000 + 32'(i);
            tick();
            if (load_done_out) pulses++;
        end
        check("N_last_done", 32'(load_done_out), 32'd1);
        check("ready_at_done", 32'(ready_out), 32'd0);
        load_valid_in = 1'b0;
        tick();
        check("done_cleared", 32'(load_done_out), 32'd0);
        check("ready_after", 32'(ready_out), 32'd1);
        check("done_pulses", 32'(pulses), 32'd2);
        check("k_blk0", k_block_out, 32'h1000);
        check("N_blk0", N_block_out, 32'h2000);

        // Five back-to-back k consumes
        for (int i = 1; i <= 5; i++) begin
            consumed_k_in = 1'b1;
            tick();
            check("k_step", k_block_out, 32'h1000 + 32'(i));
            check("N_hold", N_block_out, 32'h2000);
        end
        consumed_k_in = 1'b0;

        // Full N pass with wrap
        pulses = 0;
        for (int i = 1; i <= 128; i++) begin
            consumed_N_in = 1'b1;
            tick();
            if (N_wrap_out) pulses++;
            if (i == 64) check("N_mid", N_block_out, 32'h2040);
        end
        check("N_wrap_pulse", 32'(N_wrap_out), 32'd1);
        consumed_N_in = 1'b0;
        tick();
        check("N_wrap_once", 32'(pulses), 32'd1);
        check("N_wrap_clear", 32'(N_wrap_out), 32'd0);
        check("N_back_to_0", N_block_out, 32'h2000);
        check("N_pass_cnt", 32'(N_pass_cnt_out), 32'(PASS_ONE));
        check("k_pass_cnt", 32'(k_pass_cnt_out), 32'd0);

        // Drive k pointer to 127, then start with a coincident consume
        for (int i = 0; i < 122; i++) begin
            consumed_k_in = 1'b1;
            tick();
        end
        check("k_at_127", k_block_out, 32'h107F);
        check("k_no_early_wrap", 32'(k_wrap_out), 32'd0);
        start_in = 1'b1; consumed_k_in = 1'b1;
        tick();
        start_in = 1'b0; consumed_k_in = 1'b0;
        check("start_k_rewind", k_block_out, 32'h1000);
        check("start_no_wrap", 32'(k_wrap_out), 32'd0);
        check("start_N_rewind", N_block_out, 32'h2000);
        check("start_clr_pass", 32'(N_pass_cnt_out), 32'd0);
        tick();
        check("start_no_wrap2", 32'(k_wrap_out), 32'd0);

        // Simultaneous consumes advance both
        consumed_k_in = 1'b1; consumed_N_in = 1'b1;
        tick();
        check("both_k", k_block_out, 32'h1001);
        check("both_N", N_block_out, 32'h2001);
        consumed_k_in = 1'b0;
        tick();
        tick();
        consumed_N_in = 1'b0;
        check("N_at_3", N_block_out, 32'h2003);

        // Rewrite N blocks 0..2 unchanged, then overwrite block 3 under the read pointer
        for (int i = 0; i < 3; i++) begin
            load_valid_in = 1'b1; load_sel_in = 1'b1; load_block_in = 32'h2000 + 32'(i);
            tick();
        end
        check("N_before_ovw", N_block_out, 32'h2003);
        load_block_in = 32'h0000DEAD;
        tick();
        load_valid_in = 1'b0;
        check("N_overwrite", N_block_out, 32'h0000DEAD);
        check("ovw_no_done", 32'(load_done_out), 32'd0);
        check("ovw_ready", 32'(ready_out), 32'd1);

        // Asynchronous reset between edges
        consumed_k_in = 1'b1;
        tick();
        consumed_k_in = 1'b0;
        check("pre_rst_k", k_block_out, 32'h1002);
        #3;
        rst_in = 1'b1;
        #1;
        check("async_ready", 32'(ready_out), 32'd0);
        check("async_k_blk0", k_block_out, 32'h1000);
        check("async_N_blk0", N_block_out, 32'h2000);
        check("async_N_pass", 32'(N_pass_cnt_out), 32'd0);
        tick();
        rst_in = 1'b0;
        tick();
        check("post_rst_ready", 32'(ready_out), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
